// File: rtl/snpu_spike_tx.sv
// rtl/snpu_spike_tx.sv - outbound spike-event FIFO and 4-phase req/ack byte transmitter

// Event queue: strict-order FIFO, pointers wrap modulo DEPTH, level kept separately
module snpu_spike_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // Next-state for storage, pointers and occupancy; push+pop leaves level unchanged
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

module snpu_spike_tx #(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ev_valid,
  input  logic [7:0]       ev_data,
  output logic             ev_ready,
  output logic [7:0]       tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [LVL_W-1:0] level
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       tx_req_q, tx_req_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       ack_m_q, ack_m_d;
  logic       ack_s_q, ack_s_d;
  logic       overflow_q, overflow_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       push;
  logic       drop;
  logic       pop;

  // ev_ready follows the registered level only; a same-cycle pop does not free a slot
  assign push     = ev_valid & ~fifo_full;
  assign drop     = ev_valid & fifo_full;
  assign ev_ready = ~fifo_full;
  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

  snpu_spike_tx_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (ev_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Ack synchronizer and sticky overflow; a drop wins over a same-cycle clear
  always_comb begin
    ack_m_d    = tx_ack;
    ack_s_d    = ack_m_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Synchronizer and overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m_q    <= 1'b0;
      ack_s_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ack_m_q    <= ack_m_d;
      ack_s_q    <= ack_s_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake next-state: ena only gates leaving IDLE, never aborts REQ/RELEASE
  always_comb begin
    state_d   = state_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_req_d = 1'b0;
        if (ena && !fifo_empty) begin
          pop       = 1'b1;
          tx_data_d = fifo_rdata;
          tx_req_d  = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s_q) begin
          tx_req_d = 1'b0;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ack_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Handshake FSM with registered req/data outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_snpu_spike_tx.sv
// tb/tb_snpu_spike_tx.sv - directed vector bench for snpu_spike_tx

module tb_snpu_spike_tx;
  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       ev_valid;
  logic [7:0] ev_data;
  logic       ev_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ack;
  logic       overflow;
  logic       clr_ovf;
  logic [3:0] level;

  int errors;
  int checks;

  typedef struct {
    string      name;
    logic       ev_valid;
    logic [7:0] ev_data;
    logic       ena;
    logic       tx_ack;
    logic       clr_ovf;
    logic       exp_req;
    logic [7:0] exp_data;
    logic [3:0] exp_level;
    logic       exp_ready;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  snpu_spike_tx #(
    .DEPTH (8),
    .LVL_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .ev_ready (ev_ready),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_ack   (tx_ack),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic v, input logic [7:0] d, input logic e,
                     input logic a, input logic c, input logic xr, input logic [7:0] xd,
                     input logic [3:0] xl, input logic xy, input logic xo);
    vec_t t;
    t.name = n; t.ev_valid = v; t.ev_data = d; t.ena = e; t.tx_ack = a; t.clr_ovf = c;
    t.exp_req = xr; t.exp_data = xd; t.exp_level = xl; t.exp_ready = xy; t.exp_ovf = xo;
    vecs.push_back(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [7:0] d);
    ev_valid = 1'b1;
    ev_data  = d;
    cyc();
    ev_valid = 1'b0;
  endtask

  task automatic wait_req(input logic want, input string name);
    int n;
    n = 0;
    while (tx_req !== want && n < 30) begin
      cyc();
      n++;
    end
    chk(name, 32'(tx_req), 32'(want));
  endtask

  task automatic xfer(input logic [7:0] exp, input string name);
    wait_req(1'b1, {name, "_req"});
    chk({name, "_data"}, 32'(tx_data), 32'(exp));
    tx_ack = 1'b1;
    wait_req(1'b0, {name, "_fall"});
    tx_ack = 1'b0;
  endtask

  initial begin
    int seen;
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    ev_valid = 1'b0;
    ev_data  = 8'h00;
    tx_ack   = 1'b0;
    clr_ovf  = 1'b0;

    add("rst_idle", 0, 8'h00, 0, 0, 0, 0, 8'h00, 4'd0, 1, 0);
    add("t1_push",  1, 8'hA5, 1, 0, 0, 0, 8'h00, 4'd1, 1, 0);
    add("t1_req",   0, 8'h00, 1, 0, 0, 1, 8'hA5, 4'd0, 1, 0);
    add("t1_ack_m", 0, 8'h00, 1, 1, 0, 1, 8'hA5, 4'd0, 1, 0);
    add("t1_ack_m1",0, 8'h00, 1, 1, 0, 1, 8'hA5, 4'd0, 1, 0);
    add("t1_ack_m2",0, 8'h00, 1, 1, 0, 0, 8'hA5, 4'd0, 1, 0);
    add("t1_rel_k", 0, 8'h00, 1, 0, 0, 0, 8'hA5, 4'd0, 1, 0);
    add("t1_rel_k1",0, 8'h00, 1, 0, 0, 0, 8'hA5, 4'd0, 1, 0);
    add("t1_rel_k2",0, 8'h00, 1, 0, 0, 0, 8'hA5, 4'd0, 1, 0);
    add("t1_idle",  0, 8'h00, 1, 0, 0, 0, 8'hA5, 4'd0, 1, 0);
    for (int k = 0; k < 8; k++)
      add($sformatf("t2_fill%0d", k), 1, 8'(k), 0, 0, 0, 0, 8'hA5, 4'(k + 1), (k != 7), 0);
    add("t2_drop_clr", 1, 8'h08, 0, 0, 1, 0, 8'hA5, 4'd8, 0, 1);
    add("t6_clr",      0, 8'h00, 0, 0, 1, 0, 8'hA5, 4'd8, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(tx_req), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(ev_ready), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      ev_valid = vecs[i].ev_valid;
      ev_data  = vecs[i].ev_data;
      ena      = vecs[i].ena;
      tx_ack   = vecs[i].tx_ack;
      clr_ovf  = vecs[i].clr_ovf;
      cyc();
      chk({vecs[i].name, "_req"},   32'(tx_req),   32'(vecs[i].exp_req));
      chk({vecs[i].name, "_data"},  32'(tx_data),  32'(vecs[i].exp_data));
      chk({vecs[i].name, "_level"}, 32'(level),    32'(vecs[i].exp_level));
      chk({vecs[i].name, "_ready"}, 32'(ev_ready), 32'(vecs[i].exp_ready));
      chk({vecs[i].name, "_ovf"},   32'(overflow), 32'(vecs[i].exp_ovf));
    end
    ev_valid = 1'b0;
    clr_ovf  = 1'b0;

    // drain in order
    ena = 1'b1;
    for (int k = 0; k < 8; k++) xfer(8'(k), $sformatf("t2_drain%0d", k));
    seen = 0;
    repeat (12) begin
      cyc();
      if (tx_req) seen++;
    end
    chk("t2_no_dropped_byte", 32'(seen), 32'd0);
    chk("t2_drained_level", 32'(level), 32'd0);

    // ena=0 holds off with level 3
    ena = 1'b0;
    push_ev(8'h31);
    push_ev(8'h32);
    push_ev(8'h33);
    chk("t3_level3", 32'(level), 32'd3);
    seen = 0;
    repeat (20) begin
      cyc();
      if (tx_req) seen++;
    end
    chk("t3_hold_off", 32'(seen), 32'd0);
    ena = 1'b1;
    wait_req(1'b1, "t3_req");
    ena = 1'b0;
    chk("t3_data", 32'(tx_data), 32'h31);
    tx_ack = 1'b1;
    wait_req(1'b0, "t3_fall");
    tx_ack = 1'b0;
    seen = 0;
    repeat (10) begin
      cyc();
      if (tx_req) seen++;
    end
    chk("t3_idle_blocked", 32'(seen), 32'd0);
    chk("t3_level2", 32'(level), 32'd2);

    // ack held high keeps FSM in RELEASE
    ena = 1'b1;
    xfer(8'h32, "t4_first");
    tx_ack = 1'b1;
    seen = 0;
    repeat (10) begin
      cyc();
      if (tx_req) seen++;
    end
    chk("t4_held_no_req", 32'(seen), 32'd0);
    chk("t4_level1", 32'(level), 32'd1);
    tx_ack = 1'b0;
    cyc();
    chk("t4_k0_req", 32'(tx_req), 32'd0);
    cyc();
    chk("t4_k1_req", 32'(tx_req), 32'd0);
    cyc();
    chk("t4_k2_req", 32'(tx_req), 32'd0);
    cyc();
    chk("t4_k3_req", 32'(tx_req), 32'd1);
    chk("t4_k3_data", 32'(tx_data), 32'h33);

    // fill and overflow while in REQ, then async reset between edges
    for (int k = 0; k < 9; k++) push_ev(8'h50 + 8'(k));
    chk("t5_level8", 32'(level), 32'd8);
    chk("t5_ovf", 32'(overflow), 32'd1);
    chk("t5_req_held", 32'(tx_req), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(tx_req), 32'd0);
    chk("t5_rst_level", 32'(level), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    chk("t5_rst_data", 32'(tx_data), 32'h00);
    chk("t5_rst_ready", 32'(ev_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      cyc();
      if (tx_req) seen++;
    end
    chk("t5_no_stale", 32'(seen), 32'd0);

    // push and pop on the same edge at level 4
    ena = 1'b0;
    push_ev(8'h61);
    push_ev(8'h62);
    push_ev(8'h63);
    push_ev(8'h64);
    chk("t6_level4", 32'(level), 32'd4);
    ena = 1'b1;
    push_ev(8'h65);
    chk("t6_pushpop_level", 32'(level), 32'd4);
    chk("t6_pushpop_req", 32'(tx_req), 32'd1);
    chk("t6_pushpop_data", 32'(tx_data), 32'h61);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
